// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and byte-wide RAM bus signals of mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req_valid;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_resp_valid;
  logic [31:0]           if_resp_data;
  logic                  ls_req_valid;
  logic                  ls_req_we;
  logic [1:0]            ls_req_size;
  logic [ADDR_WIDTH-1:0] ls_req_addr;
  logic [31:0]           ls_req_wdata;
  logic                  ls_resp_valid;
  logic [31:0]           ls_resp_data;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;

  // requesters and RAM side
  modport master (
    output if_req_valid, if_req_addr,
    input  if_resp_valid, if_resp_data,
    output ls_req_valid, ls_req_we, ls_req_size, ls_req_addr, ls_req_wdata,
    input  ls_resp_valid, ls_resp_data,
    output mem_din,
    input  mem_dout, mem_a, mem_wr
  );

  // arbiter side
  modport slave (
    input  if_req_valid, if_req_addr,
    output if_resp_valid, if_resp_data,
    input  ls_req_valid, ls_req_we, ls_req_size, ls_req_addr, ls_req_wdata,
    output ls_resp_valid, ls_resp_data,
    input  mem_din,
    output mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/LSU arbiter serialising word accesses onto a byte RAM port
module mem_arbiter #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         rdy_in,
  input  logic         io_buffer_full,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0]            len;
  logic [2:0]            cnt;
  logic [31:0]           wdata;
  logic [31:0]           data;
  logic                  gnt_ls;
  logic                  ls_prio;
  logic                  issued;

  logic                  grant;
  logic                  grant_ls;
  logic                  issue;
  logic [2:0]            ls_len;
  logic [1:0]            cap_lane;
  logic                  io_stall;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic [7:0]            mem_dout;
  logic                  mem_wr;
  logic                  if_resp_valid;
  logic                  ls_resp_valid;
  logic [31:0]           if_resp_data;
  logic [31:0]           ls_resp_data;

  // next state, grant decision and bus/response outputs
  always_comb begin
    state_nxt     = state;
    grant         = 1'b0;
    grant_ls      = 1'b0;
    issue         = 1'b0;
    mem_a         = '0;
    mem_dout      = 8'h00;
    mem_wr        = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;
    if_resp_data  = 32'h0;
    ls_resp_data  = 32'h0;
    ls_len        = (bus.ls_req_size == 2'b00) ? 3'd1 :
                    (bus.ls_req_size == 2'b01) ? 3'd2 : 3'd4;
    // the byte captured now was issued last cycle, one lane below the counter
    cap_lane      = cnt[1:0] - 2'd1;
    io_stall      = (addr[17:16] == IO_ADDR_HI) && io_buffer_full;
    case (state)
      IDLE: begin
        if (rdy_in && (bus.if_req_valid || bus.ls_req_valid)) begin
          grant     = 1'b1;
          grant_ls  = bus.ls_req_valid && (!bus.if_req_valid || ls_prio);
          state_nxt = (grant_ls && bus.ls_req_we) ? WRITE : READ;
        end
      end
      READ: begin
        if (rdy_in && (cnt != len)) begin
          issue = 1'b1;
          mem_a = addr + ADDR_WIDTH'(cnt);
        end
        // the last byte has been captured once the counter is full and a capture is owed
        if (issued && (cnt == len)) begin
          state_nxt = DONE;
        end
      end
      WRITE: begin
        if (rdy_in && !io_stall) begin
          issue    = 1'b1;
          mem_a    = addr + ADDR_WIDTH'(cnt);
          mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
          mem_wr   = 1'b1;
          if (cnt == len - 3'd1) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (rdy_in) begin
          state_nxt = IDLE;
          if (gnt_ls) begin
            ls_resp_valid = 1'b1;
            ls_resp_data  = data;
          end else begin
            if_resp_valid = 1'b1;
            if_resp_data  = data;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, latched transaction, byte counter and read-data assembly
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      addr    <= '0;
      len     <= 3'd0;
      cnt     <= 3'd0;
      wdata   <= 32'h0;
      data    <= 32'h0;
      gnt_ls  <= 1'b0;
      ls_prio <= 1'b1;
      issued  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt_ls  <= grant_ls;
        ls_prio <= !grant_ls;
        addr    <= grant_ls ? bus.ls_req_addr : bus.if_req_addr;
        len     <= grant_ls ? ls_len : 3'd4;
        wdata   <= grant_ls ? bus.ls_req_wdata : 32'h0;
        data    <= 32'h0;
        cnt     <= 3'd0;
        issued  <= 1'b0;
      end else begin
        issued <= issue && (state == READ);
        if (issue) begin
          cnt <= cnt + 3'd1;
        end
        if ((state == READ) && issued) begin
          data[{cap_lane, 3'b000} +: 8] <= bus.mem_din;
        end
      end
    end
  end

  assign bus.mem_a         = mem_a;
  assign bus.mem_dout      = mem_dout;
  assign bus.mem_wr        = mem_wr;
  assign bus.if_resp_valid = if_resp_valid;
  assign bus.if_resp_data  = if_resp_data;
  assign bus.ls_resp_valid = ls_resp_valid;
  assign bus.ls_resp_data  = ls_resp_data;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single byte-wide RAM/IO port of the CPU between the instruction-fetch unit and the load/store unit. It accepts one word-or-smaller transaction at a time and breaks it into consecutive byte accesses on the RAM bus. It reassembles read bytes into a little-endian word and acknowledges writes. It also stalls IO-space writes while the UART buffer is full. It sits between the core's fetch/LSB logic and the top-level memory interface of `riscv_top`.

## Interface
- ADDR_WIDTH, 32, byte address width on requester and RAM sides
- IO_ADDR_HI, 2'b11, value of addr[17:16] that marks IO space
- clk_in  in  1  system clock
- rst_n_in  in  1  synchronous reset, active low
- rdy_in  in  1  global ready; low = pause
- if_req_valid  in  1  fetch request, held until if_resp_valid
- if_req_addr  in  ADDR_WIDTH  fetch byte address (always 4-byte read)
- if_resp_valid  out  1  one-cycle pulse, if_resp_data valid
- if_resp_data  out  32  fetched word, little-endian
- ls_req_valid  in  1  LSU request, held until ls_resp_valid
- ls_req_we  in  1  1 = store, 0 = load
- ls_req_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- ls_req_addr  in  ADDR_WIDTH  LSU byte address
- ls_req_wdata  in  32  store data, low bytes used
- ls_resp_valid  out  1  one-cycle pulse: load data valid or store done
- ls_resp_data  out  32  load data, zero-extended; 0 for stores
- mem_din  in  8  RAM read byte, valid one cycle after address
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_WIDTH  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  UART TX buffer full

## Operation
- States: IDLE, READ, WRITE, DONE.
- Reset (rst_n_in=0 at a clock edge): state IDLE; all outputs 0; byte counters and assembly register 0; round-robin pointer set so the LSU wins the first tie.
- IDLE: if exactly one requester is valid, grant it. If both are valid, grant the one not granted last, then flip the pointer. Latch addr, size (fetch = 4 bytes), write data and grant id. Go to READ, or to WRITE for an LSU store.
- READ: for k = 0..n-1, drive mem_a = addr+k, mem_wr=0, one byte per cycle. Capture mem_din into byte lane k in the cycle after byte k was issued. Capture is gated by a registered "issued" flag, not by rdy_in. After the last capture, go to DONE.
- WRITE: for k = 0..n-1, drive mem_a = addr+k, mem_dout = wdata byte k, mem_wr=1. If addr[17:16]==IO_ADDR_HI and io_buffer_full=1, issue nothing that cycle (mem_wr=0, mem_a=0, counter holds). After the last byte, go to DONE.
- DONE: pulse the granted requester's resp_valid for one cycle with assembled data, zero-extended. Ignore all requests this cycle. Return to IDLE next cycle.
- Addresses are not alignment-checked. Bytes are always addr, addr+1, ...; the adder wraps modulo 2^ADDR_WIDTH.
- rdy_in=0: no new byte is issued (mem_wr=0, mem_a=0), counters and state hold, and no grant is made in IDLE. A capture owed for a byte issued in the previous ready cycle still occurs. resp_valid is not asserted while rdy_in=0; DONE holds until rdy_in=1.
- Inactive outputs: mem_a=0, mem_dout=0, mem_wr=0 in IDLE/DONE.

## Timing
- Request sampled in IDLE at cycle T, rdy_in=1 throughout.
- Read of n bytes: addresses in T+1..T+n; data captured T+2..T+n+1; resp_valid in T+n+2. Word fetch therefore responds at T+6.
- Write of n bytes: mem_wr=1 in T+1..T+n; resp_valid in T+n+1. Word store responds at T+5.
- Next grant is possible in the cycle after resp_valid, i.e. a back-to-back word fetch starts its next address at T+8.
- Each IO stall cycle and each rdy_in=0 cycle adds exactly one cycle of latency.
- Reset mid-transaction: bus outputs are 0 the cycle after the reset edge; the aborted response is never issued.

## Test plan
- Fetch only: RAM[0x100..0x103]=0x13,0x05,0x10,0x00; if_req addr 0x100 at T -> mem_a 0x100..0x103 in T+1..T+4; if_resp_valid at T+6 with data 0x00100513.
- LSU store half: addr 0x205, wdata 0xAABBCCDD -> mem_wr=1 with (0x205,0xDD), (0x206,0xCC) in T+1..T+2; ls_resp_valid at T+3. A subsequent byte load from 0x206 returns 0x000000CC.
- Tie arbitration: both requests valid from reset -> LSU served first, then fetch. With both held continuously, grants alternate LSU, IF, LSU.
- IO stall: store byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for those cycles, write issued on the 4th; resp delayed by 3.
- rdy_in low for 2 cycles after byte 1 of a word load -> captured word is still correct; resp is delayed by exactly 2 cycles.
- Reset asserted during byte 2 of a fetch -> next cycle mem_wr=0, mem_a=0, no if_resp_valid; a new fetch afterwards completes normally.
